// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and arbiter signals between the I/D requesters, the arbiter and main memory.
`timescale 1ns/1ps
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_gnt_o;
  logic              ic_beat_valid_o;
  logic [63:0]       ic_beat_o;
  logic              ic_done_o;
  logic              dc_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [31:0]       dc_wdata_i;
  logic              dc_gnt_o;
  logic              dc_rvalid_o;
  logic [31:0]       dc_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic              mem_burst_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [63:0]       mem_rdata_i;

  // Arbiter side.
  modport slave (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output ic_gnt_o, ic_beat_valid_o, ic_beat_o, ic_done_o,
           dc_gnt_o, dc_rvalid_o, dc_rdata_o,
           mem_req_o, mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o
  );

  // Requester / memory side.
  modport master (
    output ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  ic_gnt_o, ic_beat_valid_o, ic_beat_o, ic_done_o,
           dc_gnt_o, dc_rvalid_o, dc_rdata_o,
           mem_req_o, mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refill bursts and single data accesses.
// Grants one cycle after an idle-state request; responses one cycle after each memory beat.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int BURST_BEATS = 8,
  parameter int ADDR_W      = 32
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(BURST_BEATS);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(BURST_BEATS * 8 - 1);

  typedef enum logic [1:0] {IDLE, IC_BURST, DC_ACCESS} state_t;

  state_t           state;
  logic             last_ic;
  logic [CNT_W-1:0] beat_cnt;
  logic             hi_half;
  logic             beat_in;

  // Beats that arrive while the request is still outstanding are not ours to take.
  assign beat_in = bus.mem_rvalid_i && !bus.mem_req_o;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state               <= IDLE;
      last_ic             <= 1'b1;
      beat_cnt            <= '0;
      hi_half             <= 1'b0;
      bus.ic_gnt_o        <= 1'b0;
      bus.ic_beat_valid_o <= 1'b0;
      bus.ic_beat_o       <= '0;
      bus.ic_done_o       <= 1'b0;
      bus.dc_gnt_o        <= 1'b0;
      bus.dc_rvalid_o     <= 1'b0;
      bus.dc_rdata_o      <= '0;
      bus.mem_req_o       <= 1'b0;
      bus.mem_we_o        <= 1'b0;
      bus.mem_burst_o     <= 1'b0;
      bus.mem_addr_o      <= '0;
      bus.mem_wdata_o     <= '0;
    end else begin
      bus.ic_gnt_o        <= 1'b0;
      bus.ic_beat_valid_o <= 1'b0;
      bus.ic_done_o       <= 1'b0;
      bus.dc_gnt_o        <= 1'b0;
      bus.dc_rvalid_o     <= 1'b0;
      if (bus.mem_req_o && bus.mem_ready_i) begin
        bus.mem_req_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          // On a tie the side that did not win last time goes first.
          if (bus.ic_req_i && (!bus.dc_req_i || !last_ic)) begin
            state           <= IC_BURST;
            last_ic         <= 1'b1;
            bus.ic_gnt_o    <= 1'b1;
            bus.mem_req_o   <= 1'b1;
            bus.mem_burst_o <= 1'b1;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= bus.ic_addr_i & BLK_MASK;
          end else if (bus.dc_req_i) begin
            state           <= DC_ACCESS;
            last_ic         <= 1'b0;
            bus.dc_gnt_o    <= 1'b1;
            bus.mem_req_o   <= 1'b1;
            bus.mem_burst_o <= 1'b0;
            bus.mem_we_o    <= bus.dc_we_i;
            bus.mem_addr_o  <= bus.dc_addr_i;
            bus.mem_wdata_o <= bus.dc_wdata_i;
            hi_half         <= bus.dc_addr_i[2];
          end
        end
        IC_BURST: begin
          if (beat_in) begin
            bus.ic_beat_valid_o <= 1'b1;
            bus.ic_beat_o       <= bus.mem_rdata_i;
            beat_cnt            <= beat_cnt + CNT_W'(1);
            if (beat_cnt == CNT_W'(BURST_BEATS - 1)) begin
              bus.ic_done_o <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        DC_ACCESS: begin
          if (beat_in) begin
            bus.dc_rvalid_o <= 1'b1;
            bus.dc_rdata_o  <= hi_half ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level memory and arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int BB = 8;
  localparam int AW = 32;
  localparam logic [31:0] BLK = 32'(BB * 8);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW)) bus();
  mem_arbiter #(.BURST_BEATS(BB), .ADDR_W(AW)) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus.slave)
  );

  typedef struct {logic [31:0] addr; logic we; logic burst; logic [31:0] wdata;} mreq_t;
  typedef struct {logic [63:0] dat; logic done;} icb_t;

  mreq_t       exp_mem[$];
  icb_t        exp_ic[$];
  logic [31:0] exp_dc[$];
  bit          exp_dc_rd[$];
  bit          exp_gnt[$];
  logic [63:0] mem_over[logic [31:0]];

  int          tot = 0, bad = 0;
  int unsigned cyc = 0, beats_seen = 0, last_done_cyc = 0, last_dcgnt_cyc = 0;
  bit          model_last_ic = 1'b1;
  bit          mem_busy = 1'b0;
  int          force_delay = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rd64(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:3], 3'b000};
    if (mem_over.exists(w)) return mem_over[w];
    return {w ^ 32'h5A5A_0000, ~w};
  endfunction

  function automatic logic outs_or();
    return |{bus.ic_gnt_o, bus.ic_beat_valid_o, bus.ic_beat_o, bus.ic_done_o,
             bus.dc_gnt_o, bus.dc_rvalid_o, bus.dc_rdata_o, bus.mem_req_o, bus.mem_we_o,
             bus.mem_burst_o, bus.mem_addr_o, bus.mem_wdata_o};
  endfunction

  task automatic push_ic(input logic [31:0] a);
    mreq_t m;
    icb_t  e;
    exp_gnt.push_back(1'b1);
    m.addr = a & ~(BLK - 32'd1); m.we = 1'b0; m.burst = 1'b1; m.wdata = '0;
    exp_mem.push_back(m);
    for (int k = 0; k < BB; k++) begin
      e.dat  = rd64(m.addr + 32'(8 * k));
      e.done = (k == BB - 1);
      exp_ic.push_back(e);
    end
    model_last_ic = 1'b1;
  endtask

  task automatic push_dc(input logic we, input logic [31:0] a, input logic [31:0] wd);
    mreq_t m;
    logic [63:0] v;
    exp_gnt.push_back(1'b0);
    m.addr = a; m.we = we; m.burst = 1'b0; m.wdata = wd;
    exp_mem.push_back(m);
    v = rd64(a);
    exp_dc.push_back(a[2] ? v[63:32] : v[31:0]);
    exp_dc_rd.push_back(!we);
    model_last_ic = 1'b0;
  endtask

  // Output monitor: pops the scoreboard whenever the arbiter presents something.
  initial begin
    icb_t e;
    bit s, rd;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (bus.ic_gnt_o || bus.dc_gnt_o) begin
        if (bus.dc_gnt_o) last_dcgnt_cyc = cyc;
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          s = exp_gnt.pop_front();
          chk("gnt_side", {bus.ic_gnt_o, bus.dc_gnt_o}, s ? 2'b10 : 2'b01);
        end
      end
      if (bus.ic_beat_valid_o) begin
        beats_seen++;
        if (exp_ic.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          e = exp_ic.pop_front();
          chk("ic_beat", bus.ic_beat_o, e.dat);
          chk("ic_done", bus.ic_done_o, e.done);
          if (e.done) last_done_cyc = cyc;
        end
      end else if (bus.ic_done_o) chk("done_without_beat", 1, 0);
      if (bus.dc_rvalid_o) begin
        if (exp_dc.size() == 0) chk("dc_rvalid_unexpected", 1, 0);
        else begin
          d  = exp_dc.pop_front();
          rd = exp_dc_rd.pop_front();
          if (rd) chk("dc_rdata", bus.dc_rdata_o, d);
        end
      end
    end
  end

  // Memory model: random accept delay, random gaps between beats.
  initial begin
    mreq_t cap, e;
    int d, n;
    bit stable;
    bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req_o) begin
        mem_busy  = 1'b1;
        cap.addr  = bus.mem_addr_o; cap.we = bus.mem_we_o;
        cap.burst = bus.mem_burst_o; cap.wdata = bus.mem_wdata_o;
        stable    = 1'b1;
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (!bus.mem_req_o || bus.mem_addr_o !== cap.addr || bus.mem_we_o !== cap.we ||
              bus.mem_burst_o !== cap.burst || bus.mem_wdata_o !== cap.wdata) stable = 1'b0;
        end
        chk("mem_req_stable", stable, 1);
        bus.mem_ready_i = 1'b1;
        if (exp_mem.size() == 0) chk("mem_req_unexpected", 1, 0);
        else begin
          e = exp_mem.pop_front();
          chk("mem_addr", cap.addr, e.addr);
          chk("mem_we", cap.we, e.we);
          chk("mem_burst", cap.burst, e.burst);
          if (e.we) chk("mem_wdata", cap.wdata, e.wdata);
        end
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        chk("mem_req_drop", bus.mem_req_o, 0);
        n = cap.burst ? BB : 1;
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rd64(cap.addr + 32'(8 * k));
          @(negedge clk);
          bus.mem_rvalid_i = 1'b0;
        end
        mem_busy = 1'b0;
      end
    end
  end

  // One round: I and/or D requests; lag>0 raises the D request that many cycles after the I grant.
  task automatic run_pair(input bit do_ic, input logic [31:0] ic_a, input bit do_dc,
                          input bit we, input logic [31:0] dc_a, input logic [31:0] wd,
                          input int lag);
    bit ic_first, pend_dc;
    int t, since;
    ic_first = (do_ic && do_dc && lag == 0) ? !model_last_ic : do_ic;
    if (ic_first) begin
      push_ic(ic_a);
      if (do_dc) push_dc(we, dc_a, wd);
    end else begin
      if (do_dc) push_dc(we, dc_a, wd);
      if (do_ic) push_ic(ic_a);
    end
    bus.ic_addr_i = ic_a; bus.dc_we_i = we; bus.dc_addr_i = dc_a; bus.dc_wdata_i = wd;
    bus.ic_req_i  = do_ic;
    bus.dc_req_i  = do_dc && (lag == 0);
    pend_dc = do_dc && (lag > 0);
    since = -1;
    t = 0;
    while (t < 400 && (bus.ic_req_i || bus.dc_req_i || pend_dc || exp_gnt.size() != 0 ||
           exp_ic.size() != 0 || exp_dc.size() != 0 || exp_mem.size() != 0 || mem_busy)) begin
      @(negedge clk);
      t++;
      if (bus.ic_gnt_o) begin bus.ic_req_i = 1'b0; since = 0; end
      else if (since >= 0) since++;
      if (bus.dc_gnt_o) bus.dc_req_i = 1'b0;
      if (pend_dc && since >= lag) begin bus.dc_req_i = 1'b1; pend_dc = 1'b0; end
    end
    if (t >= 400) begin
      chk("round_timeout", 1, 0);
      bus.ic_req_i = 1'b0; bus.dc_req_i = 1'b0;
      exp_gnt.delete(); exp_ic.delete(); exp_dc.delete(); exp_dc_rd.delete(); exp_mem.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned b0;
    int t, p;
    logic [31:0] a;
    bus.ic_req_i = 1'b0; bus.ic_addr_i = '0; bus.dc_req_i = 1'b0;
    bus.dc_we_i = 1'b0; bus.dc_addr_i = '0; bus.dc_wdata_i = '0;
    mem_over[32'h100] = 64'hAAAA_BBBB_CCCC_DDDD;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs_or(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie straight after reset: data first, then alternating.
    run_pair(1, 32'h0000_3000, 1, 0, 32'h0000_0208, 0, 0);
    run_pair(1, 32'h0000_3440, 1, 1, 32'h0000_0500, 32'h1111_2222, 0);
    run_pair(0, 0, 1, 0, 32'h0000_0104, 0, 0);
    chk("dc_rdata_hi_half", bus.dc_rdata_o, 32'hAAAA_BBBB);
    run_pair(1, 32'h0000_1234, 0, 0, 0, 0, 0);
    chk("ic_block_addr", bus.mem_addr_o, 32'h0000_1200);
    chk("beat_cnt_wrap", dut.beat_cnt, 0);

    force_delay = 3;
    run_pair(0, 0, 1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 0);
    force_delay = -1;

    run_pair(1, 32'h0000_7780, 1, 0, 32'h0000_0104, 0, 2);
    chk("dc_gnt_after_done", last_dcgnt_cyc - last_done_cyc, 1);

    // Reset in the middle of a burst.
    a = 32'h0000_2040;
    push_ic(a);
    bus.ic_addr_i = a; bus.ic_req_i = 1'b1;
    t = 0;
    while (!bus.ic_gnt_o && t < 50) begin @(negedge clk); t++; end
    bus.ic_req_i = 1'b0;
    while (exp_ic.size() > BB - 4 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("burst_timeout", 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_zero", outs_or(), 0);
    exp_ic.delete(); exp_gnt.delete(); exp_mem.delete();
    model_last_ic = 1'b1;
    b0 = beats_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (mem_busy && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("beats_after_reset", beats_seen - b0, 0);
    b0 = beats_seen;
    run_pair(1, 32'h0000_5A00, 0, 0, 0, 0, 0);
    chk("refill_after_reset", beats_seen - b0, BB);

    for (int r = 0; r < 40; r++) begin
      p = int'($urandom_range(0, 3));
      a = $urandom & 32'hFFFF_FFFC;
      case (p)
        0: run_pair(1, $urandom, 0, 0, 0, 0, 0);
        1: run_pair(0, 0, 1, 1'($urandom_range(0, 1)), a, $urandom, 0);
        2: run_pair(1, $urandom, 1, 1'($urandom_range(0, 1)), a, $urandom, 0);
        default: begin
          run_pair(1, $urandom, 1, 1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(1, 3)));
          chk("dc_gnt_after_done_rand", last_dcgnt_cyc - last_done_cyc, 1);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
